// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} ctrl_state_t;

  localparam int DEF_PIPE_DEPTH  = 4;
  localparam int DEF_MEM_TIMEOUT = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_FREEZE = 7'b00000_00;
  localparam ctrl_out_t CTRL_FLOW   = 7'b11111_00;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use detector: a load in EX whose destination feeds a source read in ID.
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: drives enables and bubble flushes of the
// PC and the four pipeline registers, plus halt, timeout and stall statistics.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [15:0]      stall_count
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);

  ctrl_state_t        state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               load_use;
  logic               mem_stall;
  logic               freeze;
  ctrl_out_t          co;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;
  // In MEM_WAIT the outstanding access is what matters, not a fresh request
  assign freeze    = (state == RUN) ? mem_stall : !mem_ready;

  always_comb begin
    co = CTRL_FREEZE;
    case (state)
      RUN, MEM_WAIT: begin
        if (!freeze) begin
          co = CTRL_FLOW;
          if (ex_branch_taken) begin
            co.if_id_flush = 1'b1;
            co.id_ex_flush = 1'b1;
          end else if (load_use) begin
            co.pc_en       = 1'b0;
            co.if_id_en    = 1'b0;
            co.id_ex_flush = 1'b1;
          end else if (halt_req) begin
            co.pc_en       = 1'b0;
            co.if_id_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        // A late taken branch still updates PC so resume starts at the target
        if (!mem_stall) begin
          co             = CTRL_FLOW;
          co.pc_en       = ex_branch_taken;
          co.if_id_flush = 1'b1;
          co.id_ex_flush = ex_branch_taken;
        end
      end
      default: co = CTRL_FREEZE;
    endcase
    if (reset) co = CTRL_FREEZE;
  end

  assign pc_en       = co.pc_en;
  assign if_id_en    = co.if_id_en;
  assign id_ex_en    = co.id_ex_en;
  assign ex_mem_en   = co.ex_mem_en;
  assign mem_wb_en   = co.mem_wb_en;
  assign if_id_flush = co.if_id_flush;
  assign id_ex_flush = co.id_ex_flush;
  assign halted      = (state == HALTED) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (((state == RUN) || (state == MEM_WAIT)) && !co.pc_en)
        stall_count <= sat_inc(stall_count);
      case (state)
        RUN, MEM_WAIT: begin
          if (freeze) begin
            if (state == RUN) begin
              state    <= MEM_WAIT;
              wait_cnt <= WAIT_W'(1);
            end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
              mem_err  <= 1'b1;
              state    <= HALTED;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
            if (!ex_branch_taken && !load_use && halt_req) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_W'(1);
            end else begin
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            if (drain_cnt == DRAIN_W'(PIPE_DEPTH)) begin
              state     <= HALTED;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
          end
        end
        HALTED: begin
          if (!halt_req && !mem_err) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
